// File: rtl/mips_fetch_pkg.sv
// Shared constants, types and helpers for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR_WORD   = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word_t PC_INCR          = 32'h0000_0004;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'b00,
    PC_ADVANCE  = 2'b01,
    PC_REDIRECT = 2'b10
  } pc_sel_e;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic word_t align_word(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_program_counter.sv
// Program counter: async reset, stall hold, redirect load and modulo +4 advance.
module program_counter
  import mips_fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4
);

  localparam word_t RESET_PC_ALIGNED = align_word(RESET_PC);

  pc_sel_e pc_sel_s;
  word_t   pc_d;
  word_t   pc_q;

  // Redirect outranks stall because the redirecting instruction in EX is older.
  always_comb begin
    pc_sel_s = PC_ADVANCE;
    if (redirect) begin
      pc_sel_s = PC_REDIRECT;
    end else if (stall) begin
      pc_sel_s = PC_HOLD;
    end else begin
      pc_sel_s = PC_ADVANCE;
    end
  end

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_s)
      PC_REDIRECT: pc_d = align_word(redirect_target);
      PC_HOLD:     pc_d = pc_q;
      PC_ADVANCE:  pc_d = pc_q + PC_INCR;
      default:     pc_d = pc_q;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC_ALIGNED;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + PC_INCR;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC ownership plus the IF/ID pipeline register.
// Defining IF_PERF_CNT_EN adds the FetchCount/StallCount performance counters.
module instruction_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter word_t NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectTarget,
  output logic [WORD_W-1:0] ImemAddress,
  input  logic [WORD_W-1:0] ImemInstruction,
  output logic [WORD_W-1:0] IFID_Instruction,
  output logic [WORD_W-1:0] IFID_PCPlus4,
`ifdef IF_PERF_CNT_EN
  output logic [WORD_W-1:0] FetchCount,
  output logic [WORD_W-1:0] StallCount,
`endif
  output logic              IFID_Valid
);

  word_t pc_s;
  word_t pc_plus4_s;

  program_counter #(
    .RESET_PC(RESET_PC)
  ) u_program_counter (
    .clk            (Clk),
    .rst_n          (Rst),
    .stall          (Stall),
    .redirect       (Redirect),
    .redirect_target(RedirectTarget),
    .pc             (pc_s),
    .pc_plus4       (pc_plus4_s)
  );

  assign ImemAddress = pc_s;

  word_t instr_d, instr_q;
  word_t pc4_d, pc4_q;
  logic  valid_d, valid_q;

  // IF/ID next state: flush on redirect, hold on stall, otherwise capture.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (Redirect) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (Stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else begin
      instr_d = ImemInstruction;
      pc4_d   = pc_plus4_s;
      valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pc4_q;
  assign IFID_Valid       = valid_q;

`ifdef IF_PERF_CNT_EN
  word_t fetch_count_d, fetch_count_q;
  word_t stall_count_d, stall_count_q;

  // Counter next state; both wrap naturally at 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (!Redirect && !Stall) begin
      fetch_count_d = fetch_count_q + 32'h0000_0001;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (Stall && !Redirect) begin
      stall_count_d = stall_count_q + 32'h0000_0001;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage with a small ROM model.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  int tests_run;
  int tests_failed;

  instruction_fetch_stage dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .ImemAddress     (ImemAddress),
    .ImemInstruction (ImemInstruction),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
`ifdef IF_PERF_CNT_EN
    .FetchCount      (FetchCount),
    .StallCount      (StallCount),
`endif
    .IFID_Valid      (IFID_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM: two real words at 0 and 4, elsewhere a tag derived from the address.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h200f_fc18;
      32'h0000_0004: return 32'h01E0_7801;
      default:       return 32'hC000_0000 | addr;
    endcase
  endfunction

  assign ImemInstruction = rom(ImemAddress);

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    Rst            = 1'b0;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'h0000_0000;

    #12;
    check_val("rst_pc",    ImemAddress,      32'h0000_0000);
    check_val("rst_instr", IFID_Instruction, 32'h0000_0000);
    check_val("rst_pc4",   IFID_PCPlus4,     32'h0000_0000);
    check_val("rst_valid", {31'd0, IFID_Valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check_val("rst_fcnt", FetchCount, 32'd0);
    check_val("rst_scnt", StallCount, 32'd0);
`endif

    @(negedge Clk);
    Rst = 1'b1;

    step();
    check_val("e1_pc",    ImemAddress,      32'h0000_0004);
    check_val("e1_instr", IFID_Instruction, 32'h200f_fc18);
    check_val("e1_pc4",   IFID_PCPlus4,     32'h0000_0004);
    check_val("e1_valid", {31'd0, IFID_Valid}, 32'd1);
    step();
    check_val("e2_pc",    ImemAddress,      32'h0000_0008);
    check_val("e2_instr", IFID_Instruction, 32'h01E0_7801);
    check_val("e2_pc4",   IFID_PCPlus4,     32'h0000_0008);

    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_pc",    ImemAddress,      32'h0000_0008);
      check_val("stall_instr", IFID_Instruction, 32'h01E0_7801);
      check_val("stall_pc4",   IFID_PCPlus4,     32'h0000_0008);
    end
    Stall = 1'b0;
    step();
    check_val("unstall_pc",    ImemAddress,      32'h0000_000C);
    check_val("unstall_pc4",   IFID_PCPlus4,     32'h0000_000C);
    check_val("unstall_instr", IFID_Instruction, 32'hC000_0008);
    step();
    check_val("e_pc16", ImemAddress, 32'h0000_0010);

    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0040;
    step();
    check_val("redir_pc",    ImemAddress,      32'h0000_0040);
    check_val("redir_valid", {31'd0, IFID_Valid}, 32'd0);
    check_val("redir_instr", IFID_Instruction, 32'h0000_0000);
    check_val("redir_pc4",   IFID_PCPlus4,     32'h0000_0000);
    Redirect = 1'b0;
    step();
    check_val("post_redir_instr", IFID_Instruction, 32'hC000_0040);
    check_val("post_redir_valid", {31'd0, IFID_Valid}, 32'd1);
    check_val("post_redir_pc4",   IFID_PCPlus4,     32'h0000_0044);

    Stall          = 1'b1;
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0022;
    step();
    check_val("both_pc",    ImemAddress,      32'h0000_0020);
    check_val("both_valid", {31'd0, IFID_Valid}, 32'd0);
    check_val("both_instr", IFID_Instruction, 32'h0000_0000);
    Redirect = 1'b0;
    Stall    = 1'b0;
    step();
    check_val("post_both_instr", IFID_Instruction, 32'hC000_0020);
    check_val("post_both_pc4",   IFID_PCPlus4,     32'h0000_0024);

    // Asynchronous reset landing mid-cycle while stalled.
    Stall = 1'b1;
    step();
    #2;
    Rst = 1'b0;
    #1;
    check_val("arst_pc",    ImemAddress,      32'h0000_0000);
    check_val("arst_instr", IFID_Instruction, 32'h0000_0000);
    check_val("arst_pc4",   IFID_PCPlus4,     32'h0000_0000);
    check_val("arst_valid", {31'd0, IFID_Valid}, 32'd0);
    @(negedge Clk);
    Rst   = 1'b1;
    Stall = 1'b0;
    step();
    check_val("resume_pc",    ImemAddress,      32'h0000_0004);
    check_val("resume_instr", IFID_Instruction, 32'h200f_fc18);

    Redirect       = 1'b1;
    RedirectTarget = 32'hFFFF_FFFF;
    step();
    check_val("top_pc", ImemAddress, 32'hFFFF_FFFC);
    Redirect = 1'b0;
    step();
    check_val("wrap_pc",    ImemAddress,      32'h0000_0000);
    check_val("wrap_pc4",   IFID_PCPlus4,     32'h0000_0000);
    check_val("wrap_instr", IFID_Instruction, 32'hFFFF_FFFC);
    check_val("wrap_valid", {31'd0, IFID_Valid}, 32'd1);

`ifdef IF_PERF_CNT_EN
    Stall = 1'b1;
    step();
    Stall = 1'b0;
    check_val("fetch_count", FetchCount, 32'd2);
    check_val("stall_count", StallCount, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
